// File: rtl/hazard_forward_unit_pkg.sv
// Shared constants and types for the hazard/forwarding unit.
package hazard_forward_unit_pkg;

  localparam int SEL_W = 5;
  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_RF      = 5'b00001;
  localparam sel_t SEL_EXM_TOP = 5'b00010;
  localparam sel_t SEL_EXM_BOT = 5'b00100;
  localparam sel_t SEL_MWB_TOP = 5'b01000;
  localparam sel_t SEL_MWB_BOT = 5'b10000;

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } state_t;

  localparam int SLOT_ADDR_W = 4;

  typedef struct packed {
    logic valid;
    logic wr_top;
    logic wr_bot;
    logic is_load;
  } slot_flags_t;

  localparam int SLOT_FLAGS_W = $bits(slot_flags_t);

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// One ALU operand select: youngest matching lane wins, else register file.
module fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int W = SLOT_ADDR_W
) (
  input  logic [W-1:0] src,
  input  logic         used,
  input  logic         id_valid,
  input  logic         exm_ok,
  input  logic         exm_wr_top,
  input  logic         exm_wr_bot,
  input  logic [W-1:0] exm_dst_top,
  input  logic [W-1:0] exm_dst_bot,
  input  logic         mwb_ok,
  input  logic         mwb_wr_top,
  input  logic         mwb_wr_bot,
  input  logic [W-1:0] mwb_dst_top,
  input  logic [W-1:0] mwb_dst_bot,
  output sel_t         sel
);

  logic q;
  logic hit_et, hit_eb, hit_mt, hit_mb;

  always_comb begin
    q      = id_valid && used;
    hit_et = q && exm_ok && exm_wr_top && (exm_dst_top == src);
    hit_eb = q && exm_ok && exm_wr_bot && (exm_dst_bot == src);
    hit_mt = q && mwb_ok && mwb_wr_top && (mwb_dst_top == src);
    hit_mb = q && mwb_ok && mwb_wr_bot && (mwb_dst_bot == src);
    sel    = SEL_RF;
    if (hit_et)      sel = SEL_EXM_TOP;
    else if (hit_eb) sel = SEL_EXM_BOT;
    else if (hit_mt) sel = SEL_MWB_TOP;
    else if (hit_mb) sel = SEL_MWB_BOT;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding selects and load-use stall; HAZARD_STALL_CNT_EN adds stall_count.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = SLOT_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pipe_advance,
  input  logic                  flush,
  input  logic                  id_ex_valid,
  input  logic [REG_ADDR_W-1:0] id_ex_src_top,
  input  logic [REG_ADDR_W-1:0] id_ex_src_bot,
  input  logic                  id_ex_src_top_used,
  input  logic                  id_ex_src_bot_used,
  input  logic [REG_ADDR_W-1:0] id_ex_dst_top,
  input  logic [REG_ADDR_W-1:0] id_ex_dst_bot,
  input  logic                  id_ex_wr_top,
  input  logic                  id_ex_wr_bot,
  input  logic                  id_ex_is_load,
  output logic [SEL_W-1:0]      alu_input_sel_top,
  output logic [SEL_W-1:0]      alu_input_sel_bot,
`ifdef HAZARD_STALL_CNT_EN
  output logic [15:0]           stall_count,
`endif
  output logic                  stall
);

  slot_flags_t exm_f, mwb_f;
  logic [REG_ADDR_W-1:0] exm_dt, exm_db;
  logic [REG_ADDR_W-1:0] mwb_dt, mwb_db;
  state_t state, state_next;

  logic exm_ok, mwb_ok;
  logic use_top, use_bot, load_hit;

  assign exm_ok = exm_f.valid && !exm_f.is_load;
  assign mwb_ok = mwb_f.valid;

  always_comb begin
    use_top  = id_ex_src_top_used && (id_ex_src_top == exm_dt);
    use_bot  = id_ex_src_bot_used && (id_ex_src_bot == exm_dt);
    load_hit = id_ex_valid && exm_f.valid && exm_f.wr_top &&
               exm_f.is_load && (use_top || use_bot);
    stall      = 1'b0;
    state_next = state;
    unique case (state)
      RUN: begin
        if (load_hit && !flush) begin
          stall      = 1'b1;
          state_next = LOAD_STALL;
        end
      end
      LOAD_STALL: state_next = RUN;
      default:    state_next = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_next;
  end

  // A stall retires EXM into MWB and backfills EXM with a bubble.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exm_f  <= '0;
      exm_dt <= '0;
      exm_db <= '0;
      mwb_f  <= '0;
      mwb_dt <= '0;
      mwb_db <= '0;
    end else if (stall) begin
      mwb_f  <= exm_f;
      mwb_dt <= exm_dt;
      mwb_db <= exm_db;
      exm_f  <= '0;
      exm_dt <= '0;
      exm_db <= '0;
    end else if (pipe_advance) begin
      mwb_f          <= exm_f;
      mwb_dt         <= exm_dt;
      mwb_db         <= exm_db;
      exm_f.valid    <= id_ex_valid && !flush;
      exm_f.wr_top   <= id_ex_wr_top;
      exm_f.wr_bot   <= id_ex_wr_bot;
      exm_f.is_load  <= id_ex_is_load;
      exm_dt         <= id_ex_dst_top;
      exm_db         <= id_ex_dst_bot;
    end
  end

  fwd_select #(.W(REG_ADDR_W)) u_sel_top (
    .src         (id_ex_src_top),
    .used        (id_ex_src_top_used),
    .id_valid    (id_ex_valid),
    .exm_ok      (exm_ok),
    .exm_wr_top  (exm_f.wr_top),
    .exm_wr_bot  (exm_f.wr_bot),
    .exm_dst_top (exm_dt),
    .exm_dst_bot (exm_db),
    .mwb_ok      (mwb_ok),
    .mwb_wr_top  (mwb_f.wr_top),
    .mwb_wr_bot  (mwb_f.wr_bot),
    .mwb_dst_top (mwb_dt),
    .mwb_dst_bot (mwb_db),
    .sel         (alu_input_sel_top)
  );

  fwd_select #(.W(REG_ADDR_W)) u_sel_bot (
    .src         (id_ex_src_bot),
    .used        (id_ex_src_bot_used),
    .id_valid    (id_ex_valid),
    .exm_ok      (exm_ok),
    .exm_wr_top  (exm_f.wr_top),
    .exm_wr_bot  (exm_f.wr_bot),
    .exm_dst_top (exm_dt),
    .exm_dst_bot (exm_db),
    .mwb_ok      (mwb_ok),
    .mwb_wr_top  (mwb_f.wr_top),
    .mwb_wr_bot  (mwb_f.wr_bot),
    .mwb_dst_top (mwb_dt),
    .mwb_dst_bot (mwb_db),
    .sel         (alu_input_sel_bot)
  );

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      stall_count <= '0;
    else if (stall && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding, load-use stall, reset.
module tb_hazard_forward_unit;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pipe_advance, flush, id_ex_valid;
  logic [3:0] id_ex_src_top, id_ex_src_bot;
  logic       id_ex_src_top_used, id_ex_src_bot_used;
  logic [3:0] id_ex_dst_top, id_ex_dst_bot;
  logic       id_ex_wr_top, id_ex_wr_bot, id_ex_is_load;
  logic [4:0] sel_top, sel_bot;
  logic       stall;
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;

  hazard_forward_unit #(.REG_ADDR_W(4)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .pipe_advance       (pipe_advance),
    .flush              (flush),
    .id_ex_valid        (id_ex_valid),
    .id_ex_src_top      (id_ex_src_top),
    .id_ex_src_bot      (id_ex_src_bot),
    .id_ex_src_top_used (id_ex_src_top_used),
    .id_ex_src_bot_used (id_ex_src_bot_used),
    .id_ex_dst_top      (id_ex_dst_top),
    .id_ex_dst_bot      (id_ex_dst_bot),
    .id_ex_wr_top       (id_ex_wr_top),
    .id_ex_wr_bot       (id_ex_wr_bot),
    .id_ex_is_load      (id_ex_is_load),
    .alu_input_sel_top  (sel_top),
    .alu_input_sel_bot  (sel_bot),
`ifdef HAZARD_STALL_CNT_EN
    .stall_count        (stall_count),
`endif
    .stall              (stall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_dst(input logic [3:0] dt, input logic [3:0] db,
                         input logic wt, input logic wb, input logic ld);
    id_ex_dst_top = dt;
    id_ex_dst_bot = db;
    id_ex_wr_top  = wt;
    id_ex_wr_bot  = wb;
    id_ex_is_load = ld;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    pipe_advance = 1'b0;
    flush = 1'b0;
    id_ex_valid = 1'b0;
    id_ex_src_top = '0;
    id_ex_src_bot = '0;
    id_ex_src_top_used = 1'b0;
    id_ex_src_bot_used = 1'b0;
    set_dst(0, 0, 0, 0, 0);
    #12;
    chk("reset_sel_top", 16'(sel_top), 16'h01);
    chk("reset_sel_bot", 16'(sel_bot), 16'h01);
    chk("reset_stall", 16'(stall), 16'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // ADD r3 (top dst) then consumer of r3
    id_ex_valid = 1'b1;
    set_dst(3, 0, 1, 0, 0);
    pipe_advance = 1'b1;
    step();
    pipe_advance = 1'b0;
    set_dst(0, 0, 0, 0, 0);
    id_ex_src_top = 3; id_ex_src_top_used = 1'b1;
    id_ex_src_bot = 3; id_ex_src_bot_used = 1'b1;
    #1;
    chk("exm_top_fwd_top", 16'(sel_top), 16'h02);
    chk("exm_top_fwd_bot", 16'(sel_bot), 16'h02);
    id_ex_src_bot_used = 1'b0;
    #1;
    chk("unused_bot", 16'(sel_bot), 16'h01);

    // r3 on bot destination; MWB top also r3 but EXM wins
    set_dst(0, 3, 0, 1, 0);
    pipe_advance = 1'b1;
    step();
    pipe_advance = 1'b0;
    chk("exm_bot_fwd", 16'(sel_top), 16'h04);

    // r3 in EXM top and MWB bot -> youngest
    set_dst(3, 0, 1, 0, 0);
    pipe_advance = 1'b1;
    step();
    chk("youngest_wins", 16'(sel_top), 16'h02);
    flush = 1'b1;
    step();
    pipe_advance = 1'b0;
    flush = 1'b0;
    #1;
    chk("flushed_exm_mwb", 16'(sel_top), 16'h08);

    // wr=0 then wr=1 and id_ex_valid low
    set_dst(7, 0, 0, 0, 0);
    pipe_advance = 1'b1;
    step();
    pipe_advance = 1'b0;
    id_ex_src_top = 7;
    #1;
    chk("wr0_no_fwd", 16'(sel_top), 16'h01);
    set_dst(7, 0, 1, 0, 0);
    pipe_advance = 1'b1;
    step();
    pipe_advance = 1'b0;
    chk("r7_fwd", 16'(sel_top), 16'h02);
    id_ex_valid = 1'b0;
    #1;
    chk("idex_invalid", 16'(sel_top), 16'h01);
    id_ex_valid = 1'b1;

    // LOAD r5 then consumer on src_bot
    set_dst(5, 0, 1, 0, 1);
    pipe_advance = 1'b1;
    step();
    pipe_advance = 1'b0;
    set_dst(0, 0, 0, 0, 0);
    id_ex_src_top_used = 1'b0;
    id_ex_src_bot = 5; id_ex_src_bot_used = 1'b0;
    #1;
    chk("load_unused_stall", 16'(stall), 16'h0);
    id_ex_src_bot_used = 1'b1;
    #1;
    chk("load_use_stall", 16'(stall), 16'h1);
    chk("load_in_exm_no_fwd", 16'(sel_bot), 16'h01);
    step();
    chk("stall_one_cycle", 16'(stall), 16'h0);
    chk("load_fwd_mwb", 16'(sel_bot), 16'h08);
    pipe_advance = 1'b1;
    step();
    pipe_advance = 1'b0;
    chk("after_consumer", 16'(stall), 16'h0);

    // load-use with flush, then without
    id_ex_src_bot_used = 1'b0;
    set_dst(5, 0, 1, 0, 1);
    pipe_advance = 1'b1;
    step();
    pipe_advance = 1'b0;
    set_dst(0, 0, 0, 0, 0);
    id_ex_src_top = 5; id_ex_src_top_used = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_overrides", 16'(stall), 16'h0);
    flush = 1'b0;
    #1;
    chk("stall2", 16'(stall), 16'h1);
    step();
    chk("stall2_done", 16'(stall), 16'h0);
    chk("stall2_fwd", 16'(sel_top), 16'h08);

    // third load-use event
    set_dst(5, 0, 1, 0, 1);
    pipe_advance = 1'b1;
    step();
    pipe_advance = 1'b0;
    set_dst(0, 0, 0, 0, 0);
    #1;
    chk("stall3", 16'(stall), 16'h1);
    step();
`ifdef HAZARD_STALL_CNT_EN
    chk("stall_count3", stall_count, 16'd3);
`endif

    // reset mid-stall
    set_dst(5, 0, 1, 0, 1);
    pipe_advance = 1'b1;
    step();
    pipe_advance = 1'b0;
    set_dst(0, 0, 0, 0, 0);
    #1;
    chk("stall4", 16'(stall), 16'h1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_stall", 16'(stall), 16'h0);
    chk("rst_mid_sel_top", 16'(sel_top), 16'h01);
    chk("rst_mid_sel_bot", 16'(sel_bot), 16'h01);
`ifdef HAZARD_STALL_CNT_EN
    chk("rst_count", stall_count, 16'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    step();
    chk("post_rst_stall", 16'(stall), 16'h0);
    chk("post_rst_sel", 16'(sel_top), 16'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
